vfu_wb_sequencer: RTL and testbench

Transmit side of the VFU result writeback interface into the lane VRF accessor; one instance per writeback VFU, per lane. Accepts a writeback descriptor (destination register, word count, tail strobe, instruction ID) and a stream of result words from the VFU datapath. Buffers the words in a small FIFO and drives the `vfu_result_*` request signals toward the VRF accessor, holding each beat until `gnt`. Reports completion per instruction so the lane can release the destination-register hazard.

---
 rtl/vfu_wb_sequencer_pkg.sv | 40 ++++
 rtl/vfu_wb_sequencer_fifo.sv | 61 ++++++
 rtl/vfu_wb_sequencer.sv | 133 +++++++++++++
 tb/tb_vfu_wb_sequencer.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vfu_wb_sequencer_pkg.sv
// Shared types for the VFU result writeback path into the lane VRF accessor.
// Holds the VRF word/strobe/address types, the writeback descriptor, the
// sequencer state encoding and the register-to-address mapping helper.
package vfu_wb_sequencer_pkg;

  localparam int unsigned NrVregs      = 32;
  localparam int unsigned VregW        = 5;
  localparam int unsigned VrfWordsLog2 = 4;   // VRF words per vector register, per lane (log2)
  localparam int unsigned VrfAddrW     = VregW + VrfWordsLog2;
  localparam int unsigned VrfDataW     = 64;
  localparam int unsigned VrfStrbW     = VrfDataW / 8;
  localparam int unsigned InsnIdW      = 3;
  localparam int unsigned AccCntW      = 8;

  typedef logic [VregW-1:0]    vreg_t;
  typedef logic [VrfAddrW-1:0] vrf_addr_t;
  typedef logic [VrfDataW-1:0] vrf_data_t;
  typedef logic [VrfStrbW-1:0] vrf_strb_t;
  typedef logic [InsnIdW-1:0]  insn_id_t;
  typedef logic [AccCntW-1:0]  acc_cnt_t;

  // One writeback job: acc_cnt words to consecutive VRF words starting at vd.
  typedef struct packed {
    vreg_t     vd;
    acc_cnt_t  acc_cnt;
    vrf_strb_t tail_strb;
    insn_id_t  id;
  } wb_req_t;

  typedef enum logic {
    IDLE    = 1'b0,
    WORKING = 1'b1
  } wb_state_e;

  // Each vector register occupies a contiguous block of lane VRF words.
  function automatic vrf_addr_t GetVRFAddr(input vreg_t vd);
    return vrf_addr_t'(vd) << VrfWordsLog2;
  endfunction

endpackage

// File: rtl/vfu_wb_sequencer_fifo.sv
// Result word buffer for the writeback sequencer (fifo_v3-style, no fall-through).
// Data pushed at cycle t is visible on data_o from t+1. A push is allowed while
// full as long as a pop happens in the same cycle, so Depth=1 can still stream.
// Ports:
//   clk_i, rst_ni    clock, async active-low reset (empties the buffer)
//   push_i, data_i   write side (caller only pushes when !full_o || pop_i)
//   pop_i, data_o    read side (caller only pops when !empty_o)
//   full_o, empty_o  occupancy flags
module vfu_wb_sequencer_fifo #(
  parameter int unsigned Depth = 2,
  parameter type         dtype = logic
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic push_i,
  input  dtype data_i,
  input  logic pop_i,
  output dtype data_o,
  output logic full_o,
  output logic empty_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  dtype            mem_q [Depth];
  logic [PtrW-1:0] rd_ptr_q, wr_ptr_q;
  logic [CntW-1:0] count_q;

  assign full_o  = (count_q == CntW'(Depth));
  assign empty_o = (count_q == '0);
  assign data_o  = mem_q[rd_ptr_q];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) begin
        wr_ptr_q <= (wr_ptr_q == PtrW'(Depth - 1)) ? '0 : wr_ptr_q + PtrW'(1);
      end
      if (pop_i) begin
        rd_ptr_q <= (rd_ptr_q == PtrW'(Depth - 1)) ? '0 : rd_ptr_q + PtrW'(1);
      end
      if (push_i && !pop_i) begin
        count_q <= count_q + CntW'(1);
      end else if (!push_i && pop_i) begin
        count_q <= count_q - CntW'(1);
      end
    end
  end

  // Storage carries no reset; the pointers and count define what is valid.
  always_ff @(posedge clk_i) begin
    if (push_i) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/vfu_wb_sequencer.sv
// Transmit side of a VFU result writeback port into the lane VRF accessor.
// Takes a descriptor (vd, word count, tail strobe, ID) plus a stream of result
// words, buffers the words and issues one VRF write request per word, holding
// each until granted. Pulses wb_done_o with the ID when the last word is granted.
// Ports:
//   clk_i, rst_ni                     clock, async active-low reset
//   wb_req_valid_i/ready_o, wb_req_i  writeback descriptor handshake
//   res_valid_i/ready_o, res_data_i   result word stream from the VFU datapath
//   vfu_result_*                      write request toward the VRF accessor
//   wb_done_o, wb_done_id_o           completion pulse and its instruction ID
module vfu_wb_sequencer
  import vfu_wb_sequencer_pkg::*;
#(
  parameter int unsigned LaneId = 0,
  parameter int unsigned Depth  = 2
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      wb_req_valid_i,
  output logic                      wb_req_ready_o,
  input  logic [$bits(wb_req_t)-1:0] wb_req_i,
  input  logic                      res_valid_i,
  output logic                      res_ready_o,
  input  logic [VrfDataW-1:0]       res_data_i,
  output logic                      vfu_result_valid_o,
  input  logic                      vfu_result_gnt_i,
  output logic [VrfAddrW-1:0]       vfu_result_addr_o,
  output logic [VrfDataW-1:0]       vfu_result_wdata_o,
  output logic [VrfStrbW-1:0]       vfu_result_wstrb_o,
  output logic [InsnIdW-1:0]        vfu_result_id_o,
  output logic                      wb_done_o,
  output logic [InsnIdW-1:0]        wb_done_id_o
);

  wb_req_t   req;
  wb_state_e state_q;
  vrf_addr_t addr_q;
  acc_cnt_t  cnt_q;      // beats still to be granted
  acc_cnt_t  in_cnt_q;   // words still to be accepted from the VFU
  vrf_strb_t tail_strb_q;
  insn_id_t  id_q;

  logic      fifo_full, fifo_empty;
  logic      push, pop, last_beat, req_accept;
  vrf_data_t fifo_data;

  assign req = wb_req_t'(wb_req_i);

  assign vfu_result_valid_o = !fifo_empty;
  assign pop                = vfu_result_valid_o && vfu_result_gnt_i;
  assign last_beat          = (cnt_q == acc_cnt_t'(1));
  assign wb_done_o          = pop && last_beat;
  assign wb_done_id_o       = id_q;

  // The next descriptor may be taken in the very cycle the last beat is
  // granted, so back-to-back jobs see no idle bubble.
  assign wb_req_ready_o = (state_q == IDLE) || wb_done_o;
  assign req_accept     = wb_req_valid_i && wb_req_ready_o;

  // A pop this cycle frees a slot, so a full buffer may still take a word.
  assign res_ready_o = (state_q == WORKING) && (in_cnt_q != '0) && (!fifo_full || pop);
  assign push        = res_valid_i && res_ready_o;

  assign vfu_result_addr_o  = addr_q;
  assign vfu_result_wdata_o = fifo_data;
  assign vfu_result_wstrb_o = last_beat ? tail_strb_q : '1;
  assign vfu_result_id_o    = id_q;

  vfu_wb_sequencer_fifo #(
    .Depth (Depth),
    .dtype (vrf_data_t)
  ) i_result_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push),
    .data_i  (res_data_i),
    .pop_i   (pop),
    .data_o  (fifo_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Descriptor load takes priority over the per-beat updates: it only happens
  // in IDLE or on the final grant, when the old counters are finished anyway.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      cnt_q       <= '0;
      in_cnt_q    <= '0;
      tail_strb_q <= '0;
      id_q        <= '0;
    end else begin
      if (push) begin
        in_cnt_q <= in_cnt_q - acc_cnt_t'(1);
      end
      if (pop) begin
        addr_q <= addr_q + vrf_addr_t'(1);
        cnt_q  <= cnt_q - acc_cnt_t'(1);
      end
      if (req_accept) begin
        state_q     <= WORKING;
        addr_q      <= GetVRFAddr(req.vd);
        cnt_q       <= req.acc_cnt;
        in_cnt_q    <= req.acc_cnt;
        tail_strb_q <= req.tail_strb;
        id_q        <= req.id;
      end else if (wb_done_o) begin
        state_q <= IDLE;
      end
    end
  end

`ifndef SYNTHESIS
  a_acc_cnt_nonzero : assert property (@(posedge clk_i) disable iff (!rst_ni)
    req_accept |-> (req.acc_cnt != '0))
    else $error("lane %0d: writeback descriptor with zero words", LaneId);

  a_addr_no_wrap : assert property (@(posedge clk_i) disable iff (!rst_ni)
    req_accept |-> (int'(GetVRFAddr(req.vd)) + int'(req.acc_cnt) <= (1 << VrfAddrW)))
    else $error("lane %0d: writeback would wrap the VRF address", LaneId);
`endif

`ifdef DUMP_VRF_ACCESS
  always @(posedge clk_i) begin
    if (rst_ni && pop) begin
      $display("[%0t] lane %0d VRF wb addr=%0h data=%0h id=%0d",
               $time, LaneId, addr_q, fifo_data, id_q);
    end
  end
`endif

endmodule

// File: tb/tb_vfu_wb_sequencer.sv
// Bench for vfu_wb_sequencer. Two instances (Depth=2 and Depth=1) share one
// stimulus set; sel picks which one is live. A transaction-level model derives
// the expected beat list and handshake behaviour from descriptor/word counts.
module tb_vfu_wb_sequencer;
  import vfu_wb_sequencer_pkg::*;

  localparam int WordsPerVreg = 1 << VrfWordsLog2;

  typedef struct {
    vrf_addr_t addr;
    vrf_data_t data;
    vrf_strb_t strb;
    insn_id_t  id;
    logic      last;
  } beat_t;

  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  logic sel = 1'b0;
  always #5 clk_i = ~clk_i;

  logic      wb_req_valid = 1'b0, res_valid = 1'b0, gnt = 1'b0;
  wb_req_t   wb_req = '0;
  vrf_data_t res_data = '0;

  logic [1:0] v_req_ready, v_res_ready, v_valid, v_done;
  vrf_addr_t  v_addr [2];
  vrf_data_t  v_wdata [2];
  vrf_strb_t  v_wstrb [2];
  insn_id_t   v_id [2];
  insn_id_t   v_done_id [2];

  logic      wb_req_ready, res_ready, vfu_valid, wb_done;
  vrf_addr_t vfu_addr;
  vrf_data_t vfu_wdata;
  vrf_strb_t vfu_wstrb;
  insn_id_t  vfu_id, done_id;

  vfu_wb_sequencer #(.LaneId(0), .Depth(2)) u_dut_d2 (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .wb_req_valid_i(wb_req_valid && !sel), .wb_req_ready_o(v_req_ready[0]), .wb_req_i(wb_req),
    .res_valid_i(res_valid && !sel), .res_ready_o(v_res_ready[0]), .res_data_i(res_data),
    .vfu_result_valid_o(v_valid[0]), .vfu_result_gnt_i(gnt && !sel),
    .vfu_result_addr_o(v_addr[0]), .vfu_result_wdata_o(v_wdata[0]),
    .vfu_result_wstrb_o(v_wstrb[0]), .vfu_result_id_o(v_id[0]),
    .wb_done_o(v_done[0]), .wb_done_id_o(v_done_id[0])
  );

  vfu_wb_sequencer #(.LaneId(1), .Depth(1)) u_dut_d1 (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .wb_req_valid_i(wb_req_valid && sel), .wb_req_ready_o(v_req_ready[1]), .wb_req_i(wb_req),
    .res_valid_i(res_valid && sel), .res_ready_o(v_res_ready[1]), .res_data_i(res_data),
    .vfu_result_valid_o(v_valid[1]), .vfu_result_gnt_i(gnt && sel),
    .vfu_result_addr_o(v_addr[1]), .vfu_result_wdata_o(v_wdata[1]),
    .vfu_result_wstrb_o(v_wstrb[1]), .vfu_result_id_o(v_id[1]),
    .wb_done_o(v_done[1]), .wb_done_id_o(v_done_id[1])
  );

  assign wb_req_ready = v_req_ready[sel];
  assign res_ready    = v_res_ready[sel];
  assign vfu_valid    = v_valid[sel];
  assign wb_done      = v_done[sel];
  assign vfu_addr     = v_addr[sel];
  assign vfu_wdata    = v_wdata[sel];
  assign vfu_wstrb    = v_wstrb[sel];
  assign vfu_id       = v_id[sel];
  assign done_id      = v_done_id[sel];

  beat_t     exp_beat_q [$];
  insn_id_t  exp_done_q [$];
  wb_req_t   desc_q [$];
  vrf_data_t src_q [$];

  int total = 0;
  int bad = 0;
  int desc_words = 0, words_in = 0, beats_out = 0;
  int gnt_mode = 0;
  bit vfu_rand = 1'b0;
  bit took_desc = 1'b0, took_word = 1'b0;

  function automatic void checkOutput(input string name, input logic [63:0] act,
                                      input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Queue one descriptor, its source words and the beats/done it must produce.
  task automatic applyStimulus(input int vd, input int cnt, input logic [7:0] tail,
                               input int id, input vrf_data_t fixed);
    wb_req_t d;
    d.vd        = vreg_t'(vd);
    d.acc_cnt   = acc_cnt_t'(cnt);
    d.tail_strb = tail;
    d.id        = insn_id_t'(id);
    for (int i = 0; i < cnt; i++) begin
      beat_t b;
      b.data = (fixed != '0) ? fixed + vrf_data_t'(i) : {$urandom, $urandom};
      b.addr = vrf_addr_t'(vd * WordsPerVreg + i);
      b.strb = (i == cnt - 1) ? tail : 8'hFF;
      b.id   = d.id;
      b.last = (i == cnt - 1);
      src_q.push_back(b.data);
      exp_beat_q.push_back(b);
    end
    exp_done_q.push_back(d.id);
    desc_q.push_back(d);
  endtask

  // Input driver: descriptors, VFU words and grants, all changed just after posedge.
  initial begin
    forever begin
      @(posedge clk_i);
      #1;
      if (took_desc && desc_q.size() > 0) void'(desc_q.pop_front());
      if (took_word && src_q.size() > 0) void'(src_q.pop_front());
      took_desc    = 1'b0;
      took_word    = 1'b0;
      wb_req_valid = (desc_q.size() > 0);
      if (desc_q.size() > 0) wb_req = desc_q[0];
      res_valid = (src_q.size() > 0) && (!vfu_rand || ($urandom_range(0, 3) != 0));
      if (src_q.size() > 0) res_data = src_q[0];
      case (gnt_mode)
        0:       gnt = 1'b1;
        1:       gnt = ($urandom_range(0, 1) == 1);
        default: gnt = 1'b0;
      endcase
      @(negedge clk_i);
      took_desc = wb_req_valid && wb_req_ready;
      took_word = res_valid && res_ready;
    end
  end

  int        buffered, depth;
  bit        hold_pending = 1'b0;
  vrf_addr_t hold_addr;
  vrf_data_t hold_data;
  vrf_strb_t hold_strb;
  insn_id_t  hold_id;

  // Monitor: handshake expectations from word/beat counts plus the beat scoreboard.
  always @(negedge clk_i) begin
    if (rst_ni) begin
      buffered = words_in - beats_out;
      depth    = sel ? 1 : 2;
      checkOutput("valid", vfu_valid, buffered > 0);
      checkOutput("res_ready", res_ready,
                  (desc_words > words_in) && (buffered < depth || (buffered > 0 && gnt)));
      checkOutput("wb_req_ready", wb_req_ready,
                  (desc_words == beats_out) ||
                  (buffered > 0 && gnt && beats_out + 1 == desc_words));
      checkOutput("wb_done", wb_done, buffered > 0 && gnt && beats_out + 1 == desc_words);

      if (hold_pending) begin
        checkOutput("hold_valid", vfu_valid, 1);
        checkOutput("hold_addr", vfu_addr, hold_addr);
        checkOutput("hold_data", vfu_wdata, hold_data);
        checkOutput("hold_strb", vfu_wstrb, hold_strb);
        checkOutput("hold_id", vfu_id, hold_id);
      end
      hold_pending = vfu_valid && !gnt;
      hold_addr = vfu_addr; hold_data = vfu_wdata; hold_strb = vfu_wstrb; hold_id = vfu_id;

      if (vfu_valid && gnt) begin
        if (exp_beat_q.size() == 0) begin
          checkOutput("beat_unexpected", 1, 0);
        end else begin
          beat_t b;
          b = exp_beat_q.pop_front();
          checkOutput("beat_addr", vfu_addr, b.addr);
          checkOutput("beat_data", vfu_wdata, b.data);
          checkOutput("beat_strb", vfu_wstrb, b.strb);
          checkOutput("beat_id", vfu_id, b.id);
          checkOutput("done_on_last", wb_done, b.last);
        end
      end
      if (wb_done) begin
        if (exp_done_q.size() == 0) begin
          checkOutput("done_unexpected", 1, 0);
        end else begin
          checkOutput("done_id", done_id, exp_done_q.pop_front());
        end
      end

      if (wb_req_valid && wb_req_ready) desc_words += int'(wb_req.acc_cnt);
      if (res_valid && res_ready) words_in++;
      if (vfu_valid && gnt) beats_out++;
    end
  end

  // Called just after a negedge; resets both instances and flushes all bench state.
  task automatic doReset();
    rst_ni = 1'b0;
    desc_q.delete(); src_q.delete(); exp_beat_q.delete(); exp_done_q.delete();
    wb_req_valid = 1'b0; res_valid = 1'b0;
    took_desc = 1'b0; took_word = 1'b0;
    desc_words = 0; words_in = 0; beats_out = 0;
    hold_pending = 1'b0;
    #1;
    checkOutput("rst_valid", vfu_valid, 0);
    checkOutput("rst_done", wb_done, 0);
    checkOutput("rst_req_ready", wb_req_ready, 1);
    checkOutput("rst_res_ready", res_ready, 0);
    repeat (2) @(posedge clk_i);
    #2 rst_ni = 1'b1;
  endtask

  task automatic waitDrain(input string name);
    bit ok = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk_i);
      #1;
      if (desc_q.size() == 0 && src_q.size() == 0 && exp_beat_q.size() == 0 &&
          exp_done_q.size() == 0 && beats_out == desc_words && words_in == desc_words) begin
        ok = 1'b1;
        break;
      end
    end
    checkOutput(name, ok, 1);
    checkOutput({name, "_done_left"}, exp_done_q.size(), 0);
  endtask

  initial begin
    @(negedge clk_i);
    #1;
    doReset();

    // Reset in the middle of a 4-beat job once two beats are granted.
    gnt_mode = 0; vfu_rand = 1'b0;
    applyStimulus(6, 4, 8'h03, 2, '0);
    begin
      bit reached = 1'b0;
      for (int c = 0; c < 100; c++) begin
        @(negedge clk_i);
        #1;
        if (beats_out >= 2) begin
          reached = 1'b1;
          break;
        end
      end
      checkOutput("midreset_two_beats", reached, 1);
    end
    doReset();
    applyStimulus(1, 2, 8'hF0, 3, '0);
    waitDrain("after_reset_job");

    // Single-word job, then a 4-word burst under continuous grant.
    applyStimulus(3, 1, 8'h0F, 1, 64'hDEAD);
    waitDrain("single_word");
    applyStimulus(10, 4, 8'h3C, 6, '0);
    waitDrain("burst4");

    // Grant withheld for 5 cycles during a 4-word burst.
    gnt_mode = 2;
    applyStimulus(20, 4, 8'h01, 7, '0);
    repeat (5) @(posedge clk_i);
    gnt_mode = 0;
    waitDrain("backpressure");

    // Back-to-back jobs: ID 5 is waiting while ID 4 finishes.
    applyStimulus(2, 4, 8'h7F, 4, '0);
    applyStimulus(9, 3, 8'h1F, 5, '0);
    waitDrain("back_to_back");

    // Depth=1 instance with continuous grant and an always-valid VFU.
    @(negedge clk_i);
    #1;
    sel = 1'b1;
    doReset();
    for (int k = 0; k < 3; k++) applyStimulus(4 + k, 3 + k, 8'h0F, k, '0);
    waitDrain("depth1_stream");

    // Random jobs, random grants and random VFU gaps on both depths.
    for (int s = 0; s < 2; s++) begin
      @(negedge clk_i);
      #1;
      sel = (s == 1);
      doReset();
      gnt_mode = 1; vfu_rand = 1'b1;
      for (int k = 0; k < 20; k++) begin
        applyStimulus($urandom_range(0, 31), $urandom_range(1, 8),
                      8'($urandom_range(0, 255)), $urandom_range(0, 7), '0);
      end
      waitDrain(s == 0 ? "random_d2" : "random_d1");
      gnt_mode = 0; vfu_rand = 1'b0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
